// File: rtl/s100_adr_bus_arbiter_pkg.sv
// Shared types and defaults for the S100 address-bus arbiter.
package s100_adr_bus_arbiter_pkg;

   // Arbiter states: CPU owns, request pending, turnarounds, DMA owns.
   typedef enum logic [2:0] {
      StCpu,
      StHoldReq,
      StTurnToDma,
      StDma,
      StTurnToCpu
   } arb_state_t;

   // Address source for the registered bus-address mux.
   typedef enum logic [1:0] {
      OwnCpu,
      OwnDma,
      OwnHold
   } owner_t;

   localparam int unsigned DefTurnCycles    = 2;
   localparam int unsigned DefMaxBurst      = 256;
   localparam int unsigned DefTimeoutCycles = 4096;

   // Which source drives busAdr while in a given state; turnarounds hold the last address.
   function automatic owner_t ownerOf(input arb_state_t st);
      owner_t own;
      unique case (st)
         StCpu, StHoldReq: own = OwnCpu;
         StDma:            own = OwnDma;
         default:          own = OwnHold;
      endcase
      return own;
   endfunction

endpackage

// File: rtl/s100_adr_out_mux.sv
// Registered S100 bus-address select with I/O-cycle high-byte zeroing for the CPU source.
module s100_adr_out_mux
   import s100_adr_bus_arbiter_pkg::*;
(
   input  logic        pll0_250MHz,
   input  logic        n_reset,
   input  owner_t      ownerSel,
   input  logic [15:0] cpuAdr,
   input  logic        ioCycle,
   input  logic [15:0] dmaAdr,
   output logic [15:0] busAdr
);

   // Load the selected source each cycle; OwnHold keeps the previous address on the bus.
   always_ff @(posedge pll0_250MHz or negedge n_reset) begin
      if (!n_reset) begin
         busAdr <= 16'h0000;
      end else begin
         unique case (ownerSel)
            OwnCpu:  busAdr <= {(ioCycle ? 8'h00 : cpuAdr[15:8]), cpuAdr[7:0]};
            OwnDma:  busAdr <= dmaAdr;
            default: busAdr <= busAdr;
         endcase
      end
   end

endmodule

// File: rtl/s100_adr_bus_arbiter.sv
// S100 address-bus arbiter: CPU vs. one DMA requester, with BUSRQ/BUSAK handshake.
// Optional watchdog on HOLD_REQ and DMA states: define ARB_TIMEOUT_EN.
module s100_adr_bus_arbiter
   import s100_adr_bus_arbiter_pkg::*;
#(
   parameter int unsigned TURN_CYCLES    = DefTurnCycles,
   parameter int unsigned MAX_BURST      = DefMaxBurst,
   parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
   input  logic        pll0_250MHz,
   input  logic        n_reset,
   input  logic [15:0] cpuAdr,
   input  logic        sOUT,
   input  logic        sINP,
   input  logic        cpuBusak,
   output logic        cpuBusrq,
   input  logic        dmaReq,
   input  logic [15:0] dmaAdr,
   input  logic        dmaCycle,
   input  logic        dmaDone,
   output logic        dmaGnt,
   output logic [15:0] busAdr,
   output logic        busOe,
   output logic        arbTimeout
);

   localparam logic [3:0]  TurnLast = 4'(TURN_CYCLES - 1);
   localparam logic [16:0] BurstMax = 17'(MAX_BURST);

   arb_state_t  state;
   arb_state_t  nextState;
   logic [3:0]  turnCnt;
   logic [15:0] burstCnt;
   logic [16:0] burstNext;
   logic        turnDone;
   logic        burstExit;
   logic        timeoutHit;
   owner_t      adrSel;

`ifdef ARB_TIMEOUT_EN
   localparam logic [15:0] WdLast = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] wdCnt;
   logic        timeoutFlag;

   assign timeoutHit = ((state == StHoldReq) || (state == StDma)) && (wdCnt == WdLast);
   assign arbTimeout = timeoutFlag;

   // Watchdog: cycles spent in HOLD_REQ/DMA since state entry; the flag is sticky.
   always_ff @(posedge pll0_250MHz or negedge n_reset) begin
      if (!n_reset) begin
         wdCnt       <= 16'h0000;
         timeoutFlag <= 1'b0;
      end else begin
         if (nextState != state) begin
            wdCnt <= 16'h0000;
         end else if ((state == StHoldReq) || (state == StDma)) begin
            wdCnt <= wdCnt + 16'd1;
         end else begin
            wdCnt <= 16'h0000;
         end
         if (timeoutHit) begin
            timeoutFlag <= 1'b1;
         end
      end
   end
`else
   logic unusedTimeoutCfg;

   assign timeoutHit       = 1'b0;
   assign arbTimeout       = 1'b0;
   assign unusedTimeoutCfg = (TIMEOUT_CYCLES == 0);
`endif

   // Next-state decode from the current state and handshake inputs.
   always_comb begin
      turnDone  = (turnCnt == TurnLast);
      burstNext = {1'b0, burstCnt} + {16'h0000, dmaCycle};
      // A final dmaCycle coincident with dmaDone is counted in burstNext and exits once.
      burstExit = dmaDone | ~dmaReq | (burstNext >= BurstMax) | timeoutHit;
      nextState = state;
      unique case (state)
         StCpu: begin
            if (dmaReq) nextState = StHoldReq;
         end
         StHoldReq: begin
            // Without BUSAK the CPU never let go, so drop BUSRQ and skip the turnaround.
            if (!dmaReq || timeoutHit) begin
               nextState = cpuBusak ? StTurnToCpu : StCpu;
            end else if (cpuBusak) begin
               nextState = StTurnToDma;
            end
         end
         StTurnToDma: begin
            if (turnDone) nextState = StDma;
         end
         StDma: begin
            if (burstExit) nextState = StTurnToCpu;
         end
         StTurnToCpu: begin
            if (turnDone) nextState = StCpu;
         end
         default: nextState = StCpu;
      endcase
   end

   assign adrSel = ownerOf(nextState);

   // State register and registered outputs, all derived from the state being entered.
   always_ff @(posedge pll0_250MHz or negedge n_reset) begin
      if (!n_reset) begin
         state    <= StCpu;
         cpuBusrq <= 1'b0;
         dmaGnt   <= 1'b0;
         busOe    <= 1'b0;
         turnCnt  <= 4'h0;
         burstCnt <= 16'h0000;
      end else begin
         state    <= nextState;
         cpuBusrq <= (nextState != StCpu);
         dmaGnt   <= (nextState == StDma);
         busOe    <= (nextState == StCpu) || (nextState == StHoldReq) || (nextState == StDma);
         if (nextState != state) begin
            turnCnt <= 4'h0;
         end else if ((state == StTurnToDma) || (state == StTurnToCpu)) begin
            turnCnt <= turnCnt + 4'd1;
         end else begin
            turnCnt <= 4'h0;
         end
         if ((nextState == StDma) && (state != StDma)) begin
            burstCnt <= 16'h0000;
         end else if (state == StDma) begin
            burstCnt <= burstNext[15:0];
         end
      end
   end

   s100_adr_out_mux uAdrMux (
      .pll0_250MHz (pll0_250MHz),
      .n_reset     (n_reset),
      .ownerSel    (adrSel),
      .cpuAdr      (cpuAdr),
      .ioCycle     (sOUT | sINP),
      .dmaAdr      (dmaAdr),
      .busAdr      (busAdr)
   );

endmodule

// File: doc/s100_adr_bus_arbiter.md
# s100_adr_bus_arbiter

Arbitrates the S100 address bus between the Z80 CPU and one DMA requester (the SD-card block-transfer engine), and sequences the bus-request/bus-acknowledge handshake that parks the CPU. Drives the registered 16-bit bus address, applying the I/O-cycle high-byte zeroing under CPU ownership. Sits between the CPU core and the S100 address drivers, in the pll0_250MHz domain.

## Interface
- TURN_CYCLES, 2: idle turnaround cycles between owners (1..15).
- MAX_BURST, 256: DMA bus cycles per grant before forced release (1..65535).
- TIMEOUT_CYCLES, 4096: watchdog limit for HOLD_REQ and DMA states (only with ARB_TIMEOUT_EN).
- pll0_250MHz  in  1  sole clock, all logic on rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- cpuAdr  in  16  CPU address.
- sOUT, sINP  in  1 each  CPU I/O output / input cycle status.
- cpuBusak  in  1  CPU bus acknowledge, active high (already synchronised).
- cpuBusrq  out  1  request CPU to release bus, active high.
- dmaReq  in  1  DMA wants the bus; held high until dmaGnt or withdrawn.
- dmaAdr  in  16  DMA address.
- dmaCycle  in  1  one-cycle pulse per completed DMA bus cycle.
- dmaDone  in  1  DMA finished; release bus.
- dmaGnt  out  1  DMA owns the bus.
- busAdr  out  16  registered bus address.
- busOe  out  1  address drivers enabled.
- arbTimeout  out  1  sticky watchdog flag (constant 0 without ARB_TIMEOUT_EN).

## Operation
- States: CPU, HOLD_REQ, TURN_TO_DMA, DMA, TURN_TO_CPU.
- CPU: busOe=1; busAdr = {(sOUT|sINP) ? 8'h00 : cpuAdr[15:8], cpuAdr[7:0]}. dmaReq=1 -> HOLD_REQ.
- HOLD_REQ: cpuBusrq=1, busAdr keeps tracking CPU. cpuBusak=1 -> TURN_TO_DMA. dmaReq falls before cpuBusak -> TURN_TO_CPU only if cpuBusak was seen, else straight to CPU with cpuBusrq dropped.
- TURN_TO_DMA: busOe=0, busAdr holds; counts TURN_CYCLES, then -> DMA.
- DMA: dmaGnt=1, busOe=1, busAdr = dmaAdr (no I/O zeroing). 16-bit burst counter increments on dmaCycle; dmaDone, dmaReq low, or counter reaching MAX_BURST -> TURN_TO_CPU. dmaDone and final dmaCycle in same cycle: count then exit, single exit.
- TURN_TO_CPU: dmaGnt=0, busOe=0, cpuBusrq held 1 for TURN_CYCLES, then cpuBusrq=0 -> CPU. A new dmaReq during TURN_TO_CPU is not honoured until one full cycle in CPU (CPU always gets ≥1 state cycle between grants).
- Burst counter clears on entry to DMA.

## Timing
- Reset (async assert, sync release): state CPU, busAdr=16'h0000, busOe=0 for first cycle then 1, cpuBusrq=0, dmaGnt=0, arbTimeout=0, counters 0.
- All outputs registered: one-cycle latency from any input to output.
- dmaReq rise -> cpuBusrq high next edge. cpuBusak rise -> dmaGnt high after 1 + TURN_CYCLES edges.
- Exit condition in DMA -> dmaGnt low next edge; cpuBusrq low TURN_CYCLES edges later.
- Reset mid-grant: outputs return to reset values immediately; DMA engine must treat dmaGnt fall as abort.

## Configuration
- ARB_TIMEOUT_EN defined: 16-bit watchdog counts cycles in HOLD_REQ and DMA; reaching TIMEOUT_CYCLES sets arbTimeout (sticky until n_reset) and forces TURN_TO_CPU (from HOLD_REQ with no cpuBusak: directly to CPU). Counter clears on state entry.
- Not defined: no watchdog logic; arbTimeout tied 0; HOLD_REQ waits indefinitely.

## Structure
- Shared package: state enum (arb_state_t), owner encoding, default TURN_CYCLES/MAX_BURST/TIMEOUT_CYCLES constants.
- One natural sub-module: s100_adr_out_mux (registered address select with I/O high-byte zeroing, driven by owner select).

## Test plan
- Reset then CPU I/O: cpuAdr=16'h12F3, sINP=1 -> busAdr=16'h00F3 next edge; sINP=0 -> 16'h12F3.
- DMA grant: dmaReq=1, cpuBusak after 5 cycles, TURN_CYCLES=2 -> cpuBusrq at +1, dmaGnt 3 edges after cpuBusak, busAdr=dmaAdr=16'h8000, busOe low exactly 2 cycles.
- Burst limit MAX_BURST=4: 6 dmaCycle pulses with dmaReq held -> dmaGnt falls after 4th, CPU owns ≥1 cycle, re-grant follows.
- dmaDone coincident with dmaCycle -> single TURN_TO_CPU, cpuBusrq low TURN_CYCLES later.
- Withdraw dmaReq in HOLD_REQ before cpuBusak -> cpuBusrq low next edge, dmaGnt never asserts.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, cpuBusak never asserted -> arbTimeout=1 and cpuBusrq=0 at cycle 17; n_reset pulse clears flag.
